// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - running argmax over one N_CLASSES score stream, result held until ack.
// Optional ARGMAX_MARGIN_EN adds a runner-up register and the max-minus-runner-up margin output.
module argmax_unit #(
   parameter int DATA_W    = 16,
   parameter int N_CLASSES = 10,
   parameter int IDX_W     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     ack,
   output logic                     busy,
   output logic                     in_ready,
   output logic                     res_valid,
   output logic [IDX_W-1:0]         class_idx,
   output logic signed [DATA_W-1:0] max_val
`ifdef ARGMAX_MARGIN_EN
   ,
   output logic signed [DATA_W:0]   margin
`endif
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CLEAR   = 2'd1;
   localparam logic [1:0] S_COLLECT = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_CLASSES - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] cnt;
   logic             accept;
   logic             last;
   logic             new_max;

   assign busy      = (state == S_CLEAR) || (state == S_COLLECT);
   assign in_ready  = (state == S_COLLECT);
   assign res_valid = (state == S_HOLD);

   assign accept  = in_ready && in_valid;
   assign last    = accept && (cnt == LAST_IDX);
   // First score always loads so an all-minimum stream still reports index 0.
   assign new_max = (cnt == '0) || (in_data > max_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         class_idx <= '0;
         max_val   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_CLEAR;
            end
            S_CLEAR: begin
               cnt       <= '0;
               class_idx <= '0;
               max_val   <= MOST_NEG;
               state     <= S_COLLECT;
            end
            S_COLLECT: begin
               if (accept) begin
                  if (new_max) begin
                     max_val   <= in_data;
                     class_idx <= cnt;
                  end
                  if (last) state <= S_HOLD;
                  else      cnt   <= cnt + IDX_W'(1);
               end
            end
            S_HOLD: begin
               if (ack) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ARGMAX_MARGIN_EN
   logic signed [DATA_W-1:0] runner;
   logic signed [DATA_W-1:0] runner_nxt;
   logic signed [DATA_W-1:0] max_nxt;

   // new_max already covers cnt==0, so the else branch only sees later scores.
   always_comb begin
      max_nxt    = max_val;
      runner_nxt = runner;
      if (new_max) begin
         max_nxt    = in_data;
         runner_nxt = max_val;
      end else if (in_data > runner) begin
         runner_nxt = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runner <= '0;
         margin <= '0;
      end else if (state == S_CLEAR) begin
         runner <= MOST_NEG;
         margin <= '0;
      end else if (accept) begin
         runner <= runner_nxt;
         if (last)
            margin <= {max_nxt[DATA_W-1], max_nxt} - {runner_nxt[DATA_W-1], runner_nxt};
      end
   end
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// tb/tb_argmax_unit.sv - scoreboard bench for argmax_unit.
// Build with ARGMAX_MARGIN_EN to also check the margin output.
module tb_argmax_unit;
   localparam int DW = 16;
   localparam int NC = 10;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic                 ack;
   logic                 busy;
   logic                 in_ready;
   logic                 res_valid;
   logic [IW-1:0]        class_idx;
   logic signed [DW-1:0] max_val;
`ifdef ARGMAX_MARGIN_EN
   logic signed [DW:0]   margin;
`endif

   int total = 0;
   int bad   = 0;
   int scores[NC];
   int q_idx[$];
   int q_max[$];
   int q_mar[$];
   logic hold_start = 1'b0;

   argmax_unit #(.DATA_W(DW), .N_CLASSES(NC), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .ack       (ack),
      .busy      (busy),
      .in_ready  (in_ready),
      .res_valid (res_valid),
      .class_idx (class_idx),
      .max_val   (max_val)
`ifdef ARGMAX_MARGIN_EN
      ,
      .margin    (margin)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: first score loads, strict greater-than replaces, runner-up tracks second best.
   task automatic push_exp();
      int mx, id, ru;
      mx = scores[0];
      id = 0;
      ru = -32768;
      for (int i = 1; i < NC; i++) begin
         if (scores[i] > mx) begin
            ru = mx;
            mx = scores[i];
            id = i;
         end else if (scores[i] > ru) begin
            ru = scores[i];
         end
      end
      q_idx.push_back(id);
      q_max.push_back(mx & 32'hFFFF);
      q_mar.push_back((mx - ru) & 32'h1FFFF);
   endtask

   task automatic check_outputs(input string tag, input int e_idx, input int e_max, input int e_mar);
      chk({tag, "_idx"}, {28'b0, class_idx}, e_idx);
      chk({tag, "_max"}, {16'b0, max_val}, e_max);
`ifdef ARGMAX_MARGIN_EN
      chk({tag, "_margin"}, {15'b0, margin}, e_mar);
`else
      if (e_mar < 0) chk({tag, "_margin_model"}, e_mar, 0);
`endif
   endtask

   task automatic arm(input string tag);
      start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      chk({tag, "_clear_busy"}, busy, 1);
      chk({tag, "_clear_ready"}, in_ready, 0);
      @(negedge clk);
      chk({tag, "_collect_ready"}, in_ready, 1);
   endtask

   task automatic feed(input string tag, input int gap_at, input int gap_len);
      int e_idx, e_max, e_mar, w;
      push_exp();
      for (int i = 0; i < NC; i++) begin
         if (i == gap_at) begin
            in_valid = 1'b0;
            ack      = 1'b1;
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               chk({tag, "_gap_busy"}, busy, 1);
               chk({tag, "_gap_resv"}, res_valid, 0);
            end
            ack = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = DW'(scores[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, res_valid, 1);
      w = 0;
      while (!res_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      e_idx = q_idx.pop_front();
      e_max = q_max.pop_front();
      e_mar = q_mar.pop_front();
      if (!res_valid) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         check_outputs(tag, e_idx, e_max, e_mar);
         // Result must ignore scores offered while held.
         in_valid = 1'b1;
         in_data  = 16'sh7FFF;
         @(negedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         chk({tag, "_hold_resv"}, res_valid, 1);
         check_outputs({tag, "_hold"}, e_idx, e_max, e_mar);
      end
   endtask

   task automatic release_res(input string tag);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({tag, "_ack_resv"}, res_valid, 0);
      chk({tag, "_ack_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      ack      = 1'b0;
      @(negedge clk);
      check_outputs("reset", 0, 0, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ready", in_ready, 0);
      chk("reset_resv", res_valid, 0);
      @(negedge clk);
      rst = 1'b0;

      // Scores and ack outside their states do nothing.
      in_valid = 1'b1;
      ack      = 1'b1;
      in_data  = 16'sd100;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      ack      = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_resv", res_valid, 0);
      chk("idle_max", {16'b0, max_val}, 0);

      scores = '{3, -5, 7, 2, 7, 0, -1, 4, 6, 1};
      arm("t1");
      feed("t1", -1, 0);
      release_res("t1");

      for (int i = 0; i < NC; i++) scores[i] = -10 * (i + 1);
      arm("t2");
      feed("t2", -1, 0);
      release_res("t2");

      scores = '{3, -5, 7, 2, 7, 0, -1, 4, 6, 1};
      arm("t3");
      feed("t3", 4, 3);
      release_res("t3");

      // Reset after the fifth accepted score discards the partial result.
      arm("t4");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(scores[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_outputs("t4_rst", 0, 0, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_ready", in_ready, 0);
      chk("t4_rst_resv", res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
      arm("t4b");
      feed("t4b", -1, 0);
      release_res("t4b");

      // start held high: re-arm straight out of IDLE.
      hold_start = 1'b1;
      scores = '{3, -5, 7, 2, 7, 0, -1, 4, 6, 1};
      arm("t5a");
      feed("t5a", -1, 0);
      release_res("t5a");
      for (int i = 0; i < NC; i++) scores[i] = -10 * (i + 1);
      arm("t5b");
      feed("t5b", -1, 0);
      start      = 1'b0;
      hold_start = 1'b0;
      release_res("t5b");
      @(negedge clk);
      chk("t5_idle_busy", busy, 0);

      for (int i = 0; i < NC - 1; i++) scores[i] = -32768;
      scores[NC-1] = 32767;
      arm("t6");
      feed("t6", -1, 0);
      release_res("t6");

      chk("sb_empty", q_idx.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/argmax_unit.md
# argmax_unit

Classification head placed directly downstream of the dense stage. It consumes the dense layer's score stream, one signed score per cycle while `valid` is high, for exactly `N_CLASSES` scores. It tracks the running maximum and presents the winning class index (the predicted MNIST digit) and its score. The result is held until the consumer acknowledges it.

## Interface
- `DATA_W`, 16: width of signed two's-complement input scores.
- `N_CLASSES`, 10: number of scores per inference (≥2).
- `IDX_W`, 4: width of class index/counter; must satisfy 2^IDX_W ≥ N_CLASSES.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level; arms block for one inference.
- `in_valid` in 1: score present on `in_data` this cycle (driven by dense `valid`).
- `in_data` in DATA_W: signed score.
- `ack` in 1: consumer has taken result.
- `busy` out 1: block armed or collecting.
- `in_ready` out 1: block accepts scores this cycle (drives dense readout enable).
- `res_valid` out 1: result held and stable.
- `class_idx` out IDX_W: index of maximum score.
- `max_val` out DATA_W: maximum score.
- `margin` out DATA_W+1: max minus runner-up; present only with `ARGMAX_MARGIN_EN`.

## Operation
- Four-state FSM: IDLE, CLEAR, COLLECT, HOLD.
  - IDLE → CLEAR on `start`=1.
  - CLEAR → COLLECT unconditionally.
  - COLLECT → HOLD when the `N_CLASSES`-th score is accepted.
  - HOLD → IDLE on `ack`=1.
- CLEAR action: `cnt`←0, `max_val`←most-negative value (−2^(DATA_W−1)), `class_idx`←0. Runner-up is also set to most-negative.
- COLLECT: `in_ready`=1. A score is accepted when `in_valid`=1.
  - If `cnt`==0, or `in_data` > `max_val` (signed, strict), then `max_val`←`in_data` and `class_idx`←`cnt`.
  - `cnt` increments on every accepted score.
- Ties: strict compare, so the lowest index wins. The first score always loads, so an all-minimum-value stream gives `class_idx`=0.
- `in_valid` gaps in COLLECT: stall, no count.
- `in_valid` outside COLLECT: ignored.
- `start` outside IDLE: ignored.
- `busy`=1 in CLEAR and COLLECT.
- `res_valid`=1 only in HOLD. `class_idx`, `max_val` and `margin` are stable for the whole HOLD period.
- `ack` outside HOLD: ignored.
- `start` held high through HOLD→IDLE re-arms on the following cycle. Back-to-back inferences are therefore allowed.
- `cnt` never wraps: the COLLECT exit happens at `cnt`==`N_CLASSES`−1 with an accept.

## Timing
- Reset: state IDLE. `busy`, `in_ready`, `res_valid`, `class_idx`, `max_val`, `margin` and `cnt` all 0.
- `start` sampled in cycle t: CLEAR in t+1, COLLECT (`in_ready`=1) in t+2.
- Last score accepted in cycle t: `res_valid`=1 from t+1. No combinational input-to-`res_valid` path.
- Minimum inference: 1 (CLEAR) + `N_CLASSES` + 1 (ack cycle) = 12 cycles at defaults.
- Reset mid-COLLECT or mid-HOLD: immediate return to reset values. The partial result is discarded.
- Outputs are registered. `in_ready` and `busy` decode from state only.

## Configuration
- `ARGMAX_MARGIN_EN` defined:
  - Tracks the runner-up score.
  - On a new maximum, runner-up←old `max_val`.
  - Else if `in_data` > runner-up (and `cnt`≠0), runner-up←`in_data`.
  - `margin` = `max_val` − runner-up, computed in DATA_W+1 bits signed-extended, so it never overflows. It is registered and valid in HOLD.
- Not defined: no runner-up register and no `margin` port; the remaining behaviour is identical.

## Test plan
- Reset then scores 3,−5,7,2,7,0,−1,4,6,1 (DW=16): `res_valid` one cycle after 10th accept, `class_idx`=2, `max_val`=7 (tie at idx 4 loses); with macro `margin`=0.
- Scores −10,−20,…,−100: `class_idx`=0, `max_val`=−10, `margin`=10.
- Same stream as test 1 with `in_valid` low for 3 cycles after the 4th score: identical result, `busy` stays 1 throughout.
- Assert `rst` after 5th accepted score: all outputs 0 next edge. Then `start` plus scores 0,0,0,0,0,0,0,0,0,9: `class_idx`=9.
- Hold `start`=1 continuously, two streams, `ack` pulsed in HOLD: second inference begins CLEAR one cycle after IDLE. `ack`/`in_valid` pulses outside their states have no effect.
- Scores −32768 ×9 then 32767 at idx 9: `class_idx`=9, `margin`=65535 (17-bit).
